vc_output_arbiter: RTL and testbench

Output-side stage that drains a group of `vc_buffer` FIFOs onto one output link. Each cycle it grants at most one VC, using round-robin among eligible VCs. A VC is eligible when its buffer is non-empty and it holds downstream credit. The block pops the granted buffer, registers the flit onto the link, and tracks per-VC packet framing. It sits directly downstream of the per-port `vc_buffer` instances in the router output module.

---
 rtl/vc_output_arbiter_pkg.sv | 25 ++
 rtl/vc_output_arbiter_if.sv | 29 ++
 rtl/vc_output_arbiter_rr_arbiter.sv | 32 +++
 rtl/vc_output_arbiter.sv | 135 +++++++++++++
 tb/tb_vc_output_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vc_output_arbiter_pkg.sv
// Shared NoC definitions for the output arbiter: flit type encodings, type-field
// position, per-VC framing states and default sizing.
package vc_output_arbiter_pkg;

  localparam int NUM_VC_DEF  = 4;
  localparam int FLIT_W_DEF  = 10;
  localparam int CREDITS_DEF = 32;
  localparam int CRED_W_DEF  = 6;

  // The type field occupies the top TYPE_W bits of every flit.
  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_HT   = 2'b11
  } flit_type_e;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

endpackage

// File: rtl/vc_output_arbiter_if.sv
// Buffer-side, link-side and credit-return signals of the output arbiter.
// master = the arbiter itself, slave = buffers plus downstream link.
interface vc_output_arbiter_if #(
  parameter int NUM_VC = 4,
  parameter int FLIT_W = 10,
  parameter int VC_W   = $clog2(NUM_VC)
);
  logic [NUM_VC-1:0]        vc_empty;
  logic [NUM_VC*FLIT_W-1:0] vc_data;
  logic [NUM_VC-1:0]        vc_read_en;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic [VC_W-1:0]          out_vc;
  logic                     credit_in;
  logic [VC_W-1:0]          credit_vc;
  logic                     error;

  // Buffers pop on vc_read_en at the clock edge; there is no ready on the link,
  // out_valid qualifies out_flit/out_vc for exactly one cycle per flit.
  modport master (
    input  vc_empty, vc_data, credit_in, credit_vc,
    output vc_read_en, out_valid, out_flit, out_vc, error
  );

  modport slave (
    output vc_empty, vc_data, credit_in, credit_vc,
    input  vc_read_en, out_valid, out_flit, out_vc, error
  );
endinterface

// File: rtl/vc_output_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward (wrapping) and
// returns a one-hot grant plus the encoded winner index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    // Offset N wraps back to ptr itself, so the last holder is checked last.
    for (int off = 1; off <= N; off++) begin
      cand = ptr + IW'(off);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    gnt = '0;
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/vc_output_arbiter.sv
// Drains NUM_VC buffers onto one registered output link with round-robin
// arbitration, per-VC downstream credit counting and per-VC packet framing checks.
module vc_output_arbiter
  import vc_output_arbiter_pkg::*;
#(
  parameter int NUM_VC  = NUM_VC_DEF,
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int CREDITS = CREDITS_DEF,
  parameter int CRED_W  = CRED_W_DEF,
  parameter int VC_W    = $clog2(NUM_VC)
) (
  input  logic                     clk,
  input  logic                     reset,
  vc_output_arbiter_if.master      bus,
  output logic [NUM_VC*CRED_W-1:0] dbg_credit,
  output logic [NUM_VC-1:0]        dbg_vc_active
);

  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] grant;
  logic [VC_W-1:0]   win_idx;
  logic              any_grant;
  logic [NUM_VC-1:0] frame_err;
  logic [NUM_VC-1:0] ovf_err;

  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic [VC_W-1:0]   out_vc_q, out_vc_d;
  logic              error_q, error_d;

  rr_arbiter #(.N(NUM_VC), .IW(VC_W)) u_rr (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .gnt   (grant),
    .idx   (win_idx),
    .valid (any_grant)
  );

  assign bus.vc_read_en = grant;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic [CRED_W-1:0] credit_q, credit_d;
    vc_state_e         state_q, state_d;
    flit_type_e        ftype;
    logic              ret;
    logic              ovf;
    logic              ferr;

    assign ftype = flit_type_e'(bus.vc_data[i*FLIT_W + FLIT_W - TYPE_W +: TYPE_W]);
    assign ret   = bus.credit_in && (bus.credit_vc == VC_W'(i));

    assign eligible[i] = !bus.vc_empty[i] && (credit_q != '0);
    assign ovf_err[i]  = ovf;
    assign frame_err[i] = ferr;
    assign dbg_credit[i*CRED_W +: CRED_W] = credit_q;
    assign dbg_vc_active[i] = (state_q == VC_ACTIVE);

    // A grant and a return on the same VC cancel out.
    always_comb begin
      credit_d = credit_q;
      ovf      = 1'b0;
      if (grant[i] && !ret) begin
        credit_d = credit_q - CRED_W'(1);
      end else if (!grant[i] && ret) begin
        if (credit_q == CRED_W'(CREDITS)) ovf = 1'b1;
        else credit_d = credit_q + CRED_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        credit_q <= CRED_W'(CREDITS);
        state_q  <= VC_IDLE;
      end else begin
        credit_q <= credit_d;
        state_q  <= state_d;
      end
    end

    // BODY leaves the state alone; an illegal BODY in IDLE simply stays IDLE.
    always_comb begin
      state_d = state_q;
      if (grant[i]) begin
        case (ftype)
          FLIT_HEAD: state_d = VC_ACTIVE;
          FLIT_HT:   state_d = VC_IDLE;
          FLIT_TAIL: state_d = VC_IDLE;
          default:   state_d = state_q;
        endcase
      end
    end

    always_comb begin
      ferr = 1'b0;
      if (grant[i]) begin
        if (state_q == VC_IDLE)
          ferr = (ftype == FLIT_BODY) || (ftype == FLIT_TAIL);
        else
          ferr = (ftype == FLIT_HEAD) || (ftype == FLIT_HT);
      end
    end
  end

  always_comb begin
    rr_ptr_d    = any_grant ? win_idx : rr_ptr_q;
    out_valid_d = any_grant;
    out_flit_d  = any_grant ? bus.vc_data[win_idx*FLIT_W +: FLIT_W] : out_flit_q;
    out_vc_d    = any_grant ? win_idx : out_vc_q;
    error_d     = (|frame_err) || (|ovf_err);
  end

  // Reset pointer to the last VC so VC0 is searched first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= VC_W'(NUM_VC - 1);
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_vc_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_vc_q    <= out_vc_d;
      error_q     <= error_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_vc    = out_vc_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter: arbitration order, credit exhaustion and
// return, credit overflow, framing errors and asynchronous reset mid-packet.
module tb_vc_output_arbiter;
  import vc_output_arbiter_pkg::*;

  localparam int NV = 4;
  localparam int FW = 10;
  localparam int CR = 32;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic reset;
  logic [NV*CW-1:0] dbg_credit;
  logic [NV-1:0]    dbg_vc_active;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vc_output_arbiter_if #(.NUM_VC(NV), .FLIT_W(FW)) bus ();

  vc_output_arbiter #(.NUM_VC(NV), .FLIT_W(FW), .CREDITS(CR), .CRED_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.master),
    .dbg_credit    (dbg_credit),
    .dbg_vc_active (dbg_vc_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] v);
    return {t, v};
  endfunction

  function automatic logic [31:0] cred(input int i);
    return 32'(dbg_credit[i*CW +: CW]);
  endfunction

  task automatic set_all(input logic [1:0] t);
    for (int i = 0; i < NV; i++) bus.vc_data[i*FW +: FW] = mk(t, 8'(8'h10 + i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] seq_t [8];
    logic       seq_err [8];
    logic       seq_act [8];
    seq_t   = '{FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_HT, FLIT_HEAD, FLIT_HEAD, FLIT_TAIL, FLIT_BODY};
    seq_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    seq_act = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    reset         = 1'b0;
    bus.vc_empty  = '1;
    bus.vc_data   = '0;
    bus.credit_in = 1'b0;
    bus.credit_vc = '0;
    repeat (2) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_flit", 32'(bus.out_flit), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_read_en", 32'(bus.vc_read_en), 32'd0);
      step();
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_out_vc", 32'(bus.out_vc), 32'd0);
    end
    for (int i = 0; i < NV; i++) chk("idle_credit", cred(i), 32'd32);
    chk("idle_fsm", 32'(dbg_vc_active), 32'd0);

    // Round robin across all four VCs
    set_all(FLIT_HT);
    bus.vc_empty = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_read_en", 32'(bus.vc_read_en), 32'(1 << (k % 4)));
      step();
      chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
      chk("rr_out_vc", 32'(bus.out_vc), 32'(k % 4));
      chk("rr_out_flit", 32'(bus.out_flit), 32'(mk(FLIT_HT, 8'(8'h10 + k % 4))));
      chk("rr_error", 32'(bus.error), 32'd0);
    end
    bus.vc_empty = '1;
    #1;
    chk("rr_stop_read_en", 32'(bus.vc_read_en), 32'd0);
    step();
    chk("rr_stop_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < NV; i++) chk("rr_credit", cred(i), 32'd30);

    // Return the two credits consumed on each VC
    for (int k = 0; k < 8; k++) begin
      bus.credit_in = 1'b1;
      bus.credit_vc = 2'(k % 4);
      step();
      chk("ret_error", 32'(bus.error), 32'd0);
    end
    bus.credit_in = 1'b0;
    for (int i = 0; i < NV; i++) chk("ret_credit", cred(i), 32'd32);

    // VC2 alone exhausts its credit
    bus.vc_empty = 4'b1011;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk("vc2_read_en", 32'(bus.vc_read_en), 32'b0100);
      step();
      chk("vc2_out_vc", 32'(bus.out_vc), 32'd2);
    end
    #1;
    chk("vc2_starved", 32'(bus.vc_read_en), 32'd0);
    chk("vc2_credit0", cred(2), 32'd0);
    step();
    chk("vc2_no_valid", 32'(bus.out_valid), 32'd0);
    bus.credit_in = 1'b1;
    bus.credit_vc = 2'd2;
    #1;
    chk("vc2_no_bypass", 32'(bus.vc_read_en), 32'd0);
    step();
    bus.credit_in = 1'b0;
    #1;
    chk("vc2_one_more", 32'(bus.vc_read_en), 32'b0100);
    step();
    chk("vc2_extra_valid", 32'(bus.out_valid), 32'd1);
    chk("vc2_extra_vc", 32'(bus.out_vc), 32'd2);
    #1;
    chk("vc2_starved2", 32'(bus.vc_read_en), 32'd0);
    step();
    chk("vc2_no_valid2", 32'(bus.out_valid), 32'd0);
    bus.vc_empty = '1;
    for (int k = 0; k < 32; k++) begin
      bus.credit_in = 1'b1;
      bus.credit_vc = 2'd2;
      step();
    end
    bus.credit_in = 1'b0;
    chk("vc2_refill", cred(2), 32'd32);
    chk("vc2_refill_err", 32'(bus.error), 32'd0);

    // Grant and return on VC1 together; return to full VC0
    bus.vc_empty = 4'b1101;
    #1;
    chk("vc1_read_en", 32'(bus.vc_read_en), 32'b0010);
    step();
    chk("vc1_credit31", cred(1), 32'd31);
    bus.credit_in = 1'b1;
    bus.credit_vc = 2'd1;
    #1;
    chk("vc1_read_en2", 32'(bus.vc_read_en), 32'b0010);
    step();
    bus.vc_empty = '1;
    chk("vc1_cancel", cred(1), 32'd31);
    step();
    chk("vc1_refill", cred(1), 32'd32);
    chk("vc1_error", 32'(bus.error), 32'd0);
    bus.credit_vc = 2'd0;
    step();
    bus.credit_in = 1'b0;
    chk("ovf_error", 32'(bus.error), 32'd1);
    chk("ovf_credit", cred(0), 32'd32);
    step();
    chk("ovf_error_clear", 32'(bus.error), 32'd0);

    // Framing on VC3
    bus.vc_empty = 4'b0111;
    for (int k = 0; k < 8; k++) begin
      bus.vc_data[3*FW +: FW] = mk(seq_t[k], 8'(k));
      #1;
      chk("fr_read_en", 32'(bus.vc_read_en), 32'b1000);
      step();
      chk("fr_out_vc", 32'(bus.out_vc), 32'd3);
      chk("fr_out_flit", 32'(bus.out_flit), 32'(mk(seq_t[k], 8'(k))));
      chk("fr_error", 32'(bus.error), 32'(seq_err[k]));
      chk("fr_state", 32'(dbg_vc_active[3]), 32'(seq_act[k]));
    end
    bus.vc_empty = '1;
    step();
    chk("fr_error_clear", 32'(bus.error), 32'd0);
    chk("fr_valid_clear", 32'(bus.out_valid), 32'd0);
    chk("fr_credit3", cred(3), 32'd24);

    // Reset while VC0 is mid-packet
    bus.vc_empty = 4'b1110;
    for (int k = 0; k < 12; k++) begin
      bus.vc_data[0*FW +: FW] = mk((k == 0) ? FLIT_HEAD : FLIT_BODY, 8'(k));
      step();
    end
    bus.vc_empty = '1;
    chk("mid_credit20", cred(0), 32'd20);
    chk("mid_active", 32'(dbg_vc_active[0]), 32'd1);
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_flit", 32'(bus.out_flit), 32'd0);
    chk("arst_vc", 32'(bus.out_vc), 32'd0);
    chk("arst_credit", cred(0), 32'd32);
    chk("arst_fsm", 32'(dbg_vc_active), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    set_all(FLIT_HT);
    bus.vc_empty = '0;
    #1;
    chk("post_rst_read_en", 32'(bus.vc_read_en), 32'b0001);
    step();
    chk("post_rst_vc", 32'(bus.out_vc), 32'd0);
    chk("post_rst_error", 32'(bus.error), 32'd0);
    bus.vc_empty = '1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
